// File: rtl/mem_bus_arbiter_pkg.sv
// Shared defaults, FSM encoding and width helper for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int WAIT_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Round-robin pick: first set req searching upward from ptr+1 with wrap-around.
// Purely combinational; zero latency, no backpressure of its own.
module mem_bus_arbiter_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic            found;
  logic [CH_W-1:0] c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = CH_W'((int'(ptr) + k) % NUM_CH);
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = c;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multi-master front end to a single-port RAM: RR grant, WAIT_CYCLES+1 strobe cycles, one-cycle ack.
// Requestors hold req until ack; enable low blocks new grants but lets an in-flight access finish.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int WAIT_CYCLES = 1,
  parameter int CH_W        = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     busy,
  output logic [CH_W-1:0]          gnt_id,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic                     ram_read,
  output logic                     ram_write
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;

  logic [NUM_CH-1:0]   arb_gnt;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_vld;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;
  logic                sel_in_range;

  mem_bus_arbiter_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    arb_vld      = |arb_gnt;
    sel_addr     = addr[arb_idx*ADDR_W +: ADDR_W];
    sel_wdata    = wdata[arb_idx*DATA_W +: DATA_W];
    sel_we       = we[arb_idx];
    sel_in_range = 32'(sel_addr) < 32'(MEM_DEPTH);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (enable && arb_vld) begin
          gnt_d   = arb_idx;
          ptr_d   = arb_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = sel_we;
          if (sel_in_range) begin
            cnt_d   = '0;
            rd_d    = !sel_we;
            wr_d    = sel_we;
            state_d = ACCESS;
          end else begin
            // Out-of-range accesses never strobe the RAM; they complete with err.
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == WAIT_W'(WAIT_CYCLES)) begin
          if (!we_q) rdata_d = ram_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= CH_W'(NUM_CH - 1);
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    ack = (state_q == DONE) ? (NUM_CH'(1) << gnt_q) : '0;
  end

  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_read  = rd_q;
  assign ram_write = wr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order, timing and data; a monitor compares each cycle.
module tb_mem_bus_arbiter;

  localparam int NUM_CH      = 2;
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 16;
  localparam int MEM_DEPTH   = 256;
  localparam int WAIT_CYCLES = 1;
  localparam int CH_W        = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [NUM_CH-1:0]        req = '0;
  logic [NUM_CH-1:0]        we = '0;
  logic [NUM_CH*ADDR_W-1:0] addr = '0;
  logic [NUM_CH*DATA_W-1:0] wdata = '0;
  logic [NUM_CH-1:0]        ack;
  logic [DATA_W-1:0]        rdata;
  logic                     err;
  logic                     busy;
  logic [CH_W-1:0]          gnt_id;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_wdata;
  logic [DATA_W-1:0]        ram_rdata;
  logic                     ram_read;
  logic                     ram_write;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_DEPTH(MEM_DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err),
    .busy(busy), .gnt_id(gnt_id), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_read(ram_read), .ram_write(ram_write)
  );

  // RAM behind the arbiter (environment, not the reference model)
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1] = '{default: '0};
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) if (ram_write) ram_mem[ram_addr] <= ram_wdata;

  typedef struct {
    bit              we;
    bit [ADDR_W-1:0] a;
    bit [DATA_W-1:0] d;
    int              gap;
  } op_t;

  typedef struct {
    int              n;
    int              ack_cyc;
    int              ch;
    bit              oor;
    bit              we;
    bit [ADDR_W-1:0] a;
    bit [DATA_W-1:0] d;
    bit [DATA_W-1:0] rd;
  } exp_t;

  op_t  opq [NUM_CH][$];
  exp_t exp_q [$];
  bit   active [NUM_CH];
  int   gap_cnt [NUM_CH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: grant history, shadow memory, last returned data
  bit [DATA_W-1:0] gold [0:(1<<ADDR_W)-1] = '{default: '0};
  int              m_last = NUM_CH - 1;
  int              m_next = 0;
  bit [DATA_W-1:0] m_rdata = '0;
  int              m_win;
  exp_t            m_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp_v, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_last  = NUM_CH - 1;
      m_next  = 0;
      m_rdata = '0;
    end else begin
      cyc++;
      if (cyc >= m_next && enable && req != '0) begin
        m_win = -1;
        for (int k = 1; k <= NUM_CH; k++)
          if (m_win < 0 && req[(m_last + k) % NUM_CH]) m_win = (m_last + k) % NUM_CH;
        m_e.ch  = m_win;
        m_e.n   = cyc;
        m_e.we  = we[m_win];
        m_e.a   = addr[m_win*ADDR_W +: ADDR_W];
        m_e.d   = wdata[m_win*DATA_W +: DATA_W];
        m_e.oor = int'(m_e.a) >= MEM_DEPTH;
        if (m_e.oor) m_rdata = '0;
        else if (m_e.we) gold[m_e.a] = m_e.d;
        else m_rdata = gold[m_e.a];
        m_e.rd      = m_rdata;
        m_e.ack_cyc = m_e.oor ? cyc : cyc + WAIT_CYCLES + 1;
        m_next      = m_e.ack_cyc + 2;
        m_last      = m_win;
        exp_q.push_back(m_e);
      end
    end
  end

  // Requestor agents: raise req with the next queued op, drop it when ack is seen
  initial forever begin
    op_t o;
    @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!rst_n) begin
        active[ch]  = 1'b0;
        gap_cnt[ch] = 0;
        req[ch]     = 1'b0;
        opq[ch].delete();
      end else begin
        if (active[ch] && ack[ch]) begin
          active[ch] = 1'b0;
          req[ch]    = 1'b0;
        end
        if (!active[ch] && opq[ch].size() > 0) begin
          if (gap_cnt[ch] < opq[ch][0].gap) gap_cnt[ch]++;
          else begin
            o = opq[ch].pop_front();
            gap_cnt[ch] = 0;
            req[ch] = 1'b1;
            we[ch]  = o.we;
            addr[ch*ADDR_W +: ADDR_W]  = o.a;
            wdata[ch*DATA_W +: DATA_W] = o.d;
            active[ch] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the head of the expected queue every cycle
  initial forever begin
    exp_t e;
    bit has, x_strobe, x_busy, x_ack;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {ram_read, ram_write}, 0);
    end else begin
      has = exp_q.size() > 0;
      if (has) e = exp_q[0];
      x_strobe = has && !e.oor && cyc >= e.n && cyc <= e.n + WAIT_CYCLES;
      x_busy   = has && cyc >= e.n && cyc <= e.ack_cyc;
      x_ack    = has && cyc == e.ack_cyc;
      chk("ram_read", ram_read, x_strobe && !e.we);
      chk("ram_write", ram_write, x_strobe && e.we);
      chk("busy", busy, x_busy);
      chk("ack", ack, x_ack ? (1 << e.ch) : 0);
      chk("err", err, x_ack && e.oor);
      if (x_strobe) chk("ram_addr", ram_addr, e.a);
      if (x_strobe && e.we) chk("ram_wdata", ram_wdata, e.d);
      if (x_busy) chk("gnt_id", gnt_id, e.ch);
      if (x_ack) chk("rdata", rdata, e.rd);
      if (has && cyc >= e.ack_cyc) void'(exp_q.pop_front());
    end
  end

  task automatic push(input int ch, input bit w, input int a, input int d, input int gap);
    op_t o;
    o.we = w; o.a = ADDR_W'(a); o.d = DATA_W'(d); o.gap = gap;
    opq[ch].push_back(o);
  endtask

  function automatic bit quiet();
    bit q = (exp_q.size() == 0) && !busy;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (active[ch] || opq[ch].size() > 0) q = 1'b0;
    return q;
  endfunction

  task automatic drain(input string nm, input int bound);
    int n = 0;
    while (n < bound && !quiet()) begin
      @(negedge clk);
      n++;
    end
    chk(nm, quiet(), 1);
  endtask

  function automatic int raddr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 15));
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // ch0 write then ch1 read-back of the same word
    @(posedge clk); push(0, 1'b1, 1, 16'h0086, 0);
    drain("t1_drain", 50);
    chk("t1_ram1", ram_mem[1], 16'h0086);
    @(posedge clk); push(1, 1'b0, 1, 0, 0);
    drain("t2_drain", 50);

    // both channels continuously requesting: strict alternation
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      push(0, 1'b1, 2 + i, 16'hA000 + i, 0);
      push(1, 1'b0, 1 + i, 0, 0);
    end
    drain("t3_drain", 100);

    // out of range
    @(posedge clk); push(1, 1'b0, 300, 0, 0);
    drain("t4_drain", 50);

    // enable gating
    @(negedge clk); enable = 1'b0;
    @(posedge clk); push(0, 1'b0, 1, 0, 0);
    repeat (8) @(negedge clk);
    chk("t5_idle_no_grant", busy, 0);
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk); enable = 1'b0;
    chk("t5_access_started", busy, 1);
    @(posedge clk); push(1, 1'b0, 2, 0, 0); push(0, 1'b1, 3, 16'h1234, 0);
    repeat (10) @(negedge clk);
    chk("t5_blocked", busy, 0);
    enable = 1'b1;
    drain("t5_drain", 100);

    // reset mid-access
    @(posedge clk); push(0, 1'b0, 5, 0, 0); push(1, 1'b0, 6, 0, 0);
    n = 0;
    while (n < 20 && !(ram_read || ram_write)) begin @(negedge clk); n++; end
    chk("t6_strobe_seen", ram_read | ram_write, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_read", ram_read, 0);
    chk("t6_async_write", ram_write, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ack", ack, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); push(0, 1'b0, 3, 0, 0); push(1, 1'b0, 2, 0, 0);
    drain("t6_drain", 100);

    // randomized traffic with occasional enable drops
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 1) == 1)
          push(ch, 1'($urandom_range(0, 1)), raddr(), int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 8)) @(negedge clk);
      enable = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk); enable = 1'b1;
    drain("rand_drain", 4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
